// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the I2C target register file
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_WR,
        ST_WR_ACK,
        ST_RD,
        ST_RD_ACK,
        ST_WAIT_STOP
    } i2c_state_t;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h10;

endpackage

// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - SCL/SDA synchronizers and bus event pulse generation
module i2c_bus_monitor (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_level
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_hist;
    logic       sda_hist;

    // Two-flop synchronizers plus a history flop; idle bus is high, so flops reset to 1
    // to avoid a spurious edge or START right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync  <= 2'b11;
            sda_sync  <= 2'b11;
            scl_hist  <= 1'b1;
            sda_hist  <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_level <= 1'b1;
        end else begin
            scl_sync  <= {scl_sync[0], scl_in};
            sda_sync  <= {sda_sync[0], sda_in};
            scl_hist  <= scl_sync[1];
            sda_hist  <= sda_sync[1];
            scl_rise  <= scl_sync[1] & ~scl_hist;
            scl_fall  <= ~scl_sync[1] & scl_hist;
            start_det <= scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
            stop_det  <= scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];
            sda_level <= sda_sync[1];
        end
    end

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with a byte-addressed register file
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter int         DEPTH      = 16,
    localparam int        PTR_W      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             busy,
    output logic             reg_wr_en,
    output logic [PTR_W-1:0] reg_wr_addr,
    output logic [7:0]       reg_wr_data
);

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_level;

    i2c_bus_monitor u_bus_monitor (
        .clk       (clk),
        .reset     (reset),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_level (sda_level)
    );

    i2c_state_t       state;
    logic [3:0]       bit_cnt;
    logic [7:0]       rx_shift;
    logic [7:0]       tx_shift;
    logic             rw_bit;
    logic [PTR_W-1:0] ptr;
    logic [7:0]       mem [DEPTH];

    // Protocol engine: receive bits on scl_rise, change SDA only on scl_fall,
    // START/STOP override whatever state we are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 4'd0;
            rx_shift    <= 8'h00;
            tx_shift    <= 8'h00;
            rw_bit      <= 1'b0;
            ptr         <= '0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            reg_wr_en <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_WAIT_STOP: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR, ST_PTR, ST_WR: begin
                        if (scl_rise && bit_cnt != 4'd8) begin
                            rx_shift <= {rx_shift[6:0], sda_level};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_ADDR) begin
                                if (rx_shift[7:1] == SLAVE_ADDR) begin
                                    rw_bit <= rx_shift[0];
                                    sda_oe <= 1'b1;
                                    busy   <= 1'b1;
                                    state  <= ST_ADDR_ACK;
                                end else begin
                                    state <= ST_WAIT_STOP;
                                end
                            end else if (state == ST_PTR) begin
                                ptr    <= rx_shift[PTR_W-1:0];
                                sda_oe <= 1'b1;
                                state  <= ST_WR_ACK;
                            end else begin
                                mem[ptr]    <= rx_shift;
                                reg_wr_en   <= 1'b1;
                                reg_wr_addr <= ptr;
                                reg_wr_data <= rx_shift;
                                ptr         <= ptr + PTR_W'(1);
                                sda_oe      <= 1'b1;
                                state       <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_bit) begin
                                // First read bit goes out on the same edge that ends the ACK.
                                sda_oe   <= ~mem[ptr][7];
                                tx_shift <= {mem[ptr][6:0], 1'b0};
                                bit_cnt  <= 4'd1;
                                state    <= ST_RD;
                            end else begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= ST_PTR;
                            end
                        end
                    end
                    ST_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_WR;
                        end
                    end
                    ST_RD: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                ptr    <= ptr + PTR_W'(1);
                                state  <= ST_RD_ACK;
                            end else begin
                                sda_oe   <= ~tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                                bit_cnt  <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_level == NACK) begin
                                busy  <= 1'b0;
                                state <= ST_WAIT_STOP;
                            end else begin
                                tx_shift <= mem[ptr];
                                bit_cnt  <= 4'd0;
                                state    <= ST_RD;
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                        state  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       busy;
    logic       reg_wr_en;
    logic [3:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regfile dut (
        .clk         (clk),
        .reset       (reset),
        .scl_in      (scl),
        .sda_in      (sda_line),
        .sda_oe      (sda_oe),
        .busy        (busy),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  model_mem [DEPTH];
    int          model_ptr;
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_rx[$];
    logic [11:0] wq[$];
    logic [11:0] exp_wq[$];
    int          oe_high_cnt;
    int          busy_high_cnt;
    int          oe_glitch = 0;
    logic        prev_oe = 1'b0;

    always @(negedge clk) begin
        if (reg_wr_en) wq.push_back({reg_wr_addr, reg_wr_data});
        if (sda_oe) oe_high_cnt++;
        if (busy) busy_high_cnt++;
        if (scl && !reset && sda_oe !== prev_oe) oe_glitch++;
        prev_oe = sda_oe;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic qwait;
        repeat (6) @(negedge clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; qwait;
        scl = 1'b1;   qwait;
        sda_m = 1'b0; qwait;
        scl = 1'b0;   qwait;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; qwait;
        scl = 1'b1;   qwait;
        sda_m = 1'b1; qwait;
    endtask

    task automatic write_bit(input logic b);
        sda_m = b; qwait;
        scl = 1'b1; qwait; qwait;
        scl = 1'b0; qwait;
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qwait;
        scl = 1'b1; qwait;
        b = sda_line; qwait;
        scl = 1'b0; qwait;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic nack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(nack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    task automatic send_write(input logic [7:0] addr_byte, output int nacks);
        logic a;
        nacks = 0;
        bus_start;
        write_byte(addr_byte, a);
        nacks += int'(a);
        foreach (tx_q[i]) begin
            write_byte(tx_q[i], a);
            nacks += int'(a);
        end
        bus_stop;
    endtask

    task automatic send_read(input int n, output int nacks);
        logic a;
        logic [7:0] d;
        rx_q.delete();
        bus_start;
        write_byte(8'h21, a);
        nacks = int'(a);
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, d);
            rx_q.push_back(d);
        end
        bus_stop;
    endtask

    // Reference model: first byte selects the register, each later byte lands there and advances it.
    task automatic model_write;
        exp_wq.delete();
        if (tx_q.size() > 0) model_ptr = int'(tx_q[0]) % DEPTH;
        for (int i = 1; i < tx_q.size(); i++) begin
            model_mem[model_ptr] = tx_q[i];
            exp_wq.push_back({4'(model_ptr), tx_q[i]});
            model_ptr = (model_ptr + 1) % DEPTH;
        end
    endtask

    task automatic model_read(input int n);
        exp_rx.delete();
        for (int i = 0; i < n; i++) begin
            exp_rx.push_back(model_mem[model_ptr]);
            model_ptr = (model_ptr + 1) % DEPTH;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (reg_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b expected 0", reg_wr_en); end
        n_tests++; if (reg_wr_addr !== 4'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0", reg_wr_addr); end
        n_tests++; if (reg_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 00", reg_wr_data); end
    endtask

    task automatic test_write;
        int nacks;
        tx_q = '{8'h03, 8'hA5, 8'h5A};
        model_write;
        wq.delete();
        busy_high_cnt = 0;
        send_write(8'h20, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL write_acks: got %0d nacks expected 0", nacks); end
        n_tests++; if (busy_high_cnt == 0) begin n_fail++; $display("FAIL write_busy_seen: got %0d busy cycles expected >0", busy_high_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_after_stop: got %b expected 0", busy); end
        n_tests++; if (wq.size() !== exp_wq.size()) begin n_fail++; $display("FAIL write_strobe_count: got %0d expected %0d", wq.size(), exp_wq.size()); end
        for (int i = 0; i < exp_wq.size() && i < wq.size(); i++) begin
            n_tests++; if (wq[i] !== exp_wq[i]) begin n_fail++; $display("FAIL write_strobe[%0d]: got %h expected %h", i, wq[i], exp_wq[i]); end
        end
    endtask

    task automatic test_ptr_read;
        int nacks;
        tx_q = '{8'h03};
        model_write;
        wq.delete();
        send_write(8'h20, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL ptr_only_acks: got %0d expected 0", nacks); end
        n_tests++; if (wq.size() !== 0) begin n_fail++; $display("FAIL ptr_only_strobes: got %0d expected 0", wq.size()); end
        model_read(2);
        send_read(2, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL read_addr_ack: got %0d expected 0", nacks); end
        for (int i = 0; i < exp_rx.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL read_byte[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]); end
        end
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL read_sda_after_nack: got %b expected 0", sda_oe); end
    endtask

    task automatic test_mismatch;
        int nacks;
        tx_q = '{8'h00};
        wq.delete();
        oe_high_cnt = 0;
        busy_high_cnt = 0;
        send_write(8'h22, nacks);
        n_tests++; if (nacks !== 2) begin n_fail++; $display("FAIL mismatch_nacks: got %0d expected 2", nacks); end
        n_tests++; if (oe_high_cnt !== 0) begin n_fail++; $display("FAIL mismatch_sda_driven: got %0d cycles expected 0", oe_high_cnt); end
        n_tests++; if (wq.size() !== 0) begin n_fail++; $display("FAIL mismatch_strobes: got %0d expected 0", wq.size()); end
        n_tests++; if (busy_high_cnt !== 0) begin n_fail++; $display("FAIL mismatch_busy: got %0d cycles expected 0", busy_high_cnt); end
    endtask

    task automatic test_wrap;
        int nacks;
        tx_q = '{8'h0F, 8'h11, 8'h22};
        model_write;
        wq.delete();
        send_write(8'h20, nacks);
        n_tests++; if (wq.size() !== exp_wq.size()) begin n_fail++; $display("FAIL wrap_strobe_count: got %0d expected %0d", wq.size(), exp_wq.size()); end
        for (int i = 0; i < exp_wq.size() && i < wq.size(); i++) begin
            n_tests++; if (wq[i] !== exp_wq[i]) begin n_fail++; $display("FAIL wrap_strobe[%0d]: got %h expected %h", i, wq[i], exp_wq[i]); end
        end
        tx_q = '{8'h0F};
        model_write;
        send_write(8'h20, nacks);
        model_read(2);
        send_read(2, nacks);
        for (int i = 0; i < exp_rx.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL wrap_read[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]); end
        end
    endtask

    task automatic test_repeated_start;
        logic a0, a1, a2;
        logic [7:0] d;
        wq.delete();
        tx_q = '{8'h05};
        model_write;
        model_read(1);
        bus_start;
        write_byte(8'h20, a0);
        write_byte(8'h05, a1);
        bus_start;
        write_byte(8'h21, a2);
        read_byte(1'b1, d);
        bus_stop;
        n_tests++; if ({a0, a1, a2} !== 3'b000) begin n_fail++; $display("FAIL rstart_acks: got %b expected 000", {a0, a1, a2}); end
        n_tests++; if (d !== exp_rx[0]) begin n_fail++; $display("FAIL rstart_data: got %h expected %h", d, exp_rx[0]); end
        n_tests++; if (wq.size() !== 0) begin n_fail++; $display("FAIL rstart_strobes: got %0d expected 0", wq.size()); end
    endtask

    task automatic test_random;
        int nacks;
        int n;
        logic [7:0] p;
        for (int iter = 0; iter < 5; iter++) begin
            p = 8'($urandom_range(0, 255));
            n = int'($urandom_range(1, 5));
            tx_q = '{p};
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            model_write;
            wq.delete();
            send_write(8'h20, nacks);
            n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL rand_write_acks[%0d]: got %0d expected 0", iter, nacks); end
            n_tests++; if (wq.size() !== exp_wq.size()) begin n_fail++; $display("FAIL rand_strobe_count[%0d]: got %0d expected %0d", iter, wq.size(), exp_wq.size()); end
            for (int i = 0; i < exp_wq.size() && i < wq.size(); i++) begin
                n_tests++; if (wq[i] !== exp_wq[i]) begin n_fail++; $display("FAIL rand_strobe[%0d][%0d]: got %h expected %h", iter, i, wq[i], exp_wq[i]); end
            end
            tx_q = '{p};
            model_write;
            send_write(8'h20, nacks);
            model_read(n);
            send_read(n, nacks);
            for (int i = 0; i < n; i++) begin
                n_tests++; if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL rand_read[%0d][%0d]: got %h expected %h", iter, i, rx_q[i], exp_rx[i]); end
            end
        end
    endtask

    task automatic test_reset_mid_read;
        int nacks;
        logic a;
        logic b;
        tx_q = '{8'h0C, 8'h00};
        model_write;
        send_write(8'h20, nacks);
        tx_q = '{8'h0C};
        model_write;
        send_write(8'h20, nacks);
        bus_start;
        write_byte(8'h21, a);
        for (int i = 0; i < 3; i++) read_bit(b);
        sda_m = 1'b1; qwait;
        scl = 1'b1;   qwait;
        n_tests++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midread_driving: got %b expected 1", sda_oe); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_tests++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midread_reset_sda: got %b expected 0", sda_oe); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midread_reset_busy: got %b expected 0", busy); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_ptr = 0;
        repeat (4) @(negedge clk);
        n_tests++; if (dut.ptr !== 4'h0) begin n_fail++; $display("FAIL midread_ptr: got %h expected 0", dut.ptr); end
        model_read(4);
        send_read(4, nacks);
        n_tests++; if (nacks !== 0) begin n_fail++; $display("FAIL post_reset_ack: got %0d expected 0", nacks); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rx_q[i] !== exp_rx[i]) begin n_fail++; $display("FAIL post_reset_read[%0d]: got %h expected %h", i, rx_q[i], exp_rx[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_ptr_read;
        test_mismatch;
        test_wrap;
        test_repeated_start;
        test_random;
        test_reset_mid_read;
        n_tests++; if (oe_glitch !== 0) begin n_fail++; $display("FAIL sda_change_scl_high: got %0d expected 0", oe_glitch); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
